// File: rtl/add_shift_mult_param.sv
// ---------------------------------------------------------------------------
// add_shift_mult_param
//
// Sequential add-and-shift multiplier. One operand pair is accepted per
// operation. The product is built one multiplier bit per cycle, and the
// result is registered once the operation completes.
//
// Latency: the operation takes WIDTH+2 clock edges after the accepting edge.
// That is one LOAD edge, WIDTH SHIFT edges and one FIX edge. done is high
// in the cycle that follows the FIX edge.
//
// Optional feature (macro SIGNED_EN):
//   When SIGNED_EN is defined, the signed_mode port exists. When signed_mode
//   is 1, the operands are two's complement. The magnitudes are multiplied,
//   and the product is negated in FIX when the operand signs differ.
//   When SIGNED_EN is undefined, operands are always unsigned. The sign is
//   held at 0, and the FIX state and the latency do not change.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        operation request; sampled only while ready=1
//   signed_mode  1: two's complement operands (SIGNED_EN builds only)
//   a, b         multiplicand / multiplier, captured on the accepting edge
//   result       2*WIDTH product of the last completed operation
//   ready        high while idle and able to accept start
//   done         single-cycle pulse marking a new result
// ---------------------------------------------------------------------------
module add_shift_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SIGNED_EN
  input  logic               signed_mode,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIX   = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_in;    // raw operands captured on the accepting edge
  logic [WIDTH-1:0]   r_b_in;
  logic               r_sm;      // signed mode captured with the operands
  logic [WIDTH-1:0]   r_mcand;   // multiplicand magnitude
  logic [WIDTH-1:0]   r_mult;    // multiplier; low product bits shift in from the top
  logic [WIDTH-1:0]   r_p;       // high half of the running product
  logic [CW-1:0]      r_cnt;
  logic               r_sign;
  logic [2*WIDTH-1:0] r_result;
  logic               r_done;

  logic               w_sm_in;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;

`ifdef SIGNED_EN
  assign w_sm_in = signed_mode;
`else
  assign w_sm_in = 1'b0;
`endif

  // Magnitudes are computed as WIDTH-bit unsigned values. Negating the most
  // negative value gives the bit pattern 1000...0. Read as unsigned, that is
  // exactly 2^(WIDTH-1), so no extra bit is needed.
  assign w_a_neg = r_sm & r_a_in[WIDTH-1];
  assign w_b_neg = r_sm & r_b_in[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~r_a_in + ONE_W) : r_a_in;
  assign w_b_mag = w_b_neg ? (~r_b_in + ONE_W) : r_b_in;

  // The partial sum is one bit wider than an operand. Bit 0 drops into the
  // multiplier register, and the upper WIDTH bits become the new P.
  assign w_sum      = {1'b0, r_p} + (r_mult[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod     = {r_p, r_mult};
  assign w_prod_neg = ~w_prod + ONE_2W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_in   <= '0;
      r_b_in   <= '0;
      r_sm     <= 1'b0;
      r_mcand  <= '0;
      r_mult   <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_in  <= a;
            r_b_in  <= b;
            r_sm    <= w_sm_in;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_mcand <= w_a_mag;
          r_mult  <= w_b_mag;
          r_p     <= '0;
          r_cnt   <= '0;
          r_sign  <= w_a_neg ^ w_b_neg;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_p    <= w_sum[WIDTH:1];
          r_mult <= {w_sum[0], r_mult[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) r_state <= FIX;
        end
        FIX: begin
          // result changes only here, so partial products are never visible
          r_result <= r_sign ? w_prod_neg : w_prod;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign ready  = (r_state == IDLE);

endmodule

// File: tb/tb_add_shift_mult_param.sv
module tb_add_shift_mult_param;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sm;
  logic [W-1:0]  a, b;
  logic [2*W-1:0] result;
  logic          ready, done;

  int n_tests = 0;
  int n_fail  = 0;

  add_shift_mult_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef SIGNED_EN
    .signed_mode (sm),
`endif
    .a           (a),
    .b           (b),
    .result      (result),
    .ready       (ready),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] exp_s;  // expected with signed_mode honoured
    logic [2*W-1:0] exp_u;  // expected as unsigned
  } vec_t;

  // Drives one operation, then checks the latency, the ready-low window,
  // the result and that done lasts a single cycle.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vsm, input logic [2*W-1:0] exp, input string tag);
    int n;
    int lowcnt;
    @(negedge clk);
    a = va; b = vb; sm = vsm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; lowcnt = 0;
    if (!ready) lowcnt++;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!ready) lowcnt++;
    end
    chk({tag, " latency"}, n, 10);
    chk({tag, " ready_low"}, lowcnt, 10);
    chk({tag, " result"}, result, exp);
    @(posedge clk); #1;
    chk({tag, " done_single"}, done, 1'b0);
    chk({tag, " result_hold"}, result, exp);
  endtask

  vec_t vecs[10];

  initial begin
    int ndone;
    int e1, e2, ecnt;
    logic [2*W-1:0] r1, r2;

    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 16'h008F};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 16'hFE01};
    vecs[2] = '{8'd0,   8'd0,   1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{8'd0,   8'd200, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{8'd200, 8'd3,   1'b0, 16'h0258, 16'h0258};
    vecs[5] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 16'h04F1};
    vecs[6] = '{8'h80,  8'h80,  1'b1, 16'h4000, 16'h4000};
    vecs[7] = '{8'h80,  8'h01,  1'b1, 16'hFF80, 16'h0080};
    vecs[8] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF, 16'h00FF};
    vecs[9] = '{8'h7F,  8'h80,  1'b1, 16'hC080, 16'h3F80};

    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    #1;
    chk("reset result", result, 16'h0000);
    chk("reset done",   done,   1'b0);
    chk("reset ready",  ready,  1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
`ifdef SIGNED_EN
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp_s, $sformatf("vec%0d", i));
`else
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp_u, $sformatf("vec%0d", i));
`endif
    end

    // A start while busy is ignored: one done, first result intact.
    @(negedge clk);
    a = 8'd13; b = 8'd11; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 4) begin start = 1'b1; a = 8'd7; b = 8'd6; end
      else if (i == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("busy_start done_count", ndone, 1);
    chk("busy_start result", result, 16'h008F);

    // Reset in the 5th SHIFT cycle aborts the operation.
    @(negedge clk);
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort result", result, 16'h0000);
    chk("abort done",   done,   1'b0);
    chk("abort ready",  ready,  1'b1);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    run_op(8'd7, 8'd6, 1'b0, 16'h002A, "after_abort");

    // Back-to-back: start held high, operands switched while the first runs.
    @(negedge clk);
    a = 8'd13; b = 8'd11; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd7; b = 8'd6;
    ecnt = 0; e1 = -1; e2 = -1; r1 = '0; r2 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ecnt++;
        if (ecnt == 1) begin e1 = i; r1 = result; end
        else if (ecnt == 2) begin e2 = i; r2 = result; start = 1'b0; end
      end
      if (ecnt >= 2) break;
    end
    start = 1'b0;
    chk("b2b done_count", ecnt, 2);
    chk("b2b first_edge", e1, 10);
    chk("b2b spacing",   e2 - e1, 11);
    chk("b2b result1",   r1, 16'h008F);
    chk("b2b result2",   r2, 16'h002A);
    repeat (15) @(posedge clk);
    #1;
    chk("b2b idle_ready", ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_shift_mult_param.md
ADD_SHIFT_MULT_PARAM -- requirements
Module: add_shift_mult_param

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  operation request; sampled only while ready=1.
REQ-005 signed_mode  input  1  1: operands are two's complement; 0: unsigned (present only with SIGNED_EN).
REQ-006 a  input  WIDTH  multiplicand; sampled on the edge that accepts start.
REQ-007 b  input  WIDTH  multiplier; sampled on the edge that accepts start.
REQ-008 result  output  2*WIDTH  registered product of the last completed operation.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 done  output  1  single-cycle pulse marking a new valid result.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, SHIFT and FIX; no other states are reachable.
REQ-012 IDLE: ready=1; start=1 -> LOAD; otherwise stay in IDLE.
REQ-013 LOAD: operand registers load |a| and |b| (signed) or a and b (unsigned); P cleared; bit counter cleared; sign = a[MSB]^b[MSB] when signed, else 0; -> SHIFT.
REQ-014 SHIFT: each cycle P+(mult[0] ? mcand : 0) is formed at WIDTH+1 bits; P takes sum[WIDTH:1]; mult shifts right, taking sum[0] into its MSB; counter increments.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, -> FIX on the edge where counter reaches WIDTH-1.
REQ-016 FIX: result <= sign ? two's-complement negation of {P,mult} : {P,mult}; -> IDLE; done is registered high for the following cycle only.
REQ-017 Latency: done is high in the cycle after the (WIDTH+2)th rising edge following the edge that accepted start; WIDTH=8 gives 10 edges.
REQ-018 |a| of the most negative value (-2^(WIDTH-1)) SHALL be represented exactly as the unsigned magnitude 2^(WIDTH-1); no overflow.
REQ-019 start, a, b and signed_mode SHALL be ignored while ready=0; no queueing.
REQ-020 result SHALL hold its value until the next FIX state; it SHALL never show partial products.
REQ-021 A start accepted in the done cycle (ready=1) SHALL begin a new operation with no bubble.
REQ-022 Zero operands SHALL follow the full latency, with result=0 and done pulsed.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, result=0, done=0, P=0, operand registers=0, counter=0, sign=0.
REQ-024 rst asserted mid-operation SHALL abort the operation; no done pulse for it; ready=1 after rst deasserts.
REQ-025 The first rising edge with rst=0 MAY accept start.

Configuration
REQ-026 Macro SIGNED_EN: defined -> signed_mode port exists and REQ-013/REQ-016 sign handling applies.
REQ-027 SIGNED_EN undefined -> no signed_mode port; operands always unsigned; sign held at 0; FIX state and latency unchanged.

Verification (WIDTH=8)
REQ-028 unsigned a=13, b=11 -> result=0x008F, done after exactly 10 edges, ready low for 10 cycles.
REQ-029 unsigned a=255, b=255 -> result=0xFE01; signed_mode=1, a=0xFD(-3), b=5 -> result=0xFFF1.
REQ-030 signed a=0x80, b=0x80 -> result=0x4000; signed a=0x80, b=0x01 -> result=0xFF80.
REQ-031 start pulsed again in cycle 4 of a busy operation with different a,b -> ignored; first result unchanged, exactly one done.
REQ-032 rst pulsed in the 5th SHIFT cycle -> result=0, done=0, ready=1; a new start 7*6 -> 0x002A.
REQ-033 back-to-back: start held high through done -> two consecutive operations, done pulses 11 cycles apart, each result correct.
